// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment display driver
package seg_pkg;

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: 4-bit nibble to active-low segment pattern, combinational
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg_n
);

    assign o_seg_n = HEX_SEG[i_nib];

endmodule

// File: rtl/io_seg_display.sv
// io_seg_display: 8-digit multiplexed hex display of the I/O output ports
module io_seg_display
    import seg_pkg::*;
#(
    parameter int          SCAN_DIV = 50000,
    parameter int          GUARD    = 500,
    parameter int          BLANK_LZ = 1,
    parameter logic [7:0]  DP_MASK  = 8'b0101_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] out_port0,
    input  logic [31:0] out_port1,
    input  logic [31:0] out_port2,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int            CW   = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GEND = CW'(GUARD - 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_dig;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_snap0;
    logic [7:0]    r_snap1;
    logic [15:0]   r_snap2;
    logic          w_cnt_last;
    logic          w_guard_end;
    logic          w_drive;
    logic          w_snap_load;
    logic          w_lz;
    logic [31:0]   w_nibs;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;
    logic          w_unused;

    assign w_unused    = ^{out_port0[31:8], out_port1[31:8], out_port2[31:16]};
    assign w_cnt_last  = r_cnt == LAST;
    assign w_guard_end = r_cnt == GEND;
    assign w_drive     = r_state == ST_DRIVE;
    assign w_snap_load = r_state == ST_BLANK && r_dig == 3'd0 && r_cnt == '0;
    assign w_nibs      = {r_snap0, r_snap1, r_snap2};
    assign w_nib       = w_nibs[{r_dig, 2'b00} +: 4];
    // a port2 digit is a leading zero when it and every higher port2 nibble are zero
    assign w_lz        = (BLANK_LZ != 0) && r_dig >= 3'd1 && r_dig <= 3'd3 &&
                         ((r_snap2 >> {r_dig[1:0], 2'b00}) == 16'h0);

    seg_hex_decode u_dec (
        .i_nib   (w_nib),
        .o_seg_n (w_seg)
    );

    // dark guard interval first, then lit until the slot ends
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_BLANK && w_guard_end) w_state_nxt = ST_DRIVE;
        else if (w_drive && w_cnt_last) w_state_nxt = ST_BLANK;
    end

    // slot counter, digit index and FSM state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= '0;
            r_dig   <= 3'd0;
            r_state <= ST_BLANK;
        end else begin
            r_cnt   <= w_cnt_last ? '0 : r_cnt + 1'b1;
            r_dig   <= (w_drive && w_cnt_last) ? r_dig + 3'd1 : r_dig;
            r_state <= w_state_nxt;
        end
    end

    // one coherent port snapshot per frame, taken at the start of digit 0's slot
    always_ff @(posedge clock) begin
        if (reset) begin
            r_snap0 <= 8'h0;
            r_snap1 <= 8'h0;
            r_snap2 <= 16'h0;
        end else if (w_snap_load) begin
            r_snap0 <= out_port0[7:0];
            r_snap1 <= out_port1[7:0];
            r_snap2 <= out_port2[15:0];
        end
    end

    // registered display outputs, one cycle behind the scan state
    always_ff @(posedge clock) begin
        if (reset) begin
            an_n       <= 8'hFF;
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an_n       <= w_drive ? ~(8'b1 << r_dig) : 8'hFF;
            seg_n      <= (w_drive && !w_lz) ? w_seg : SEG_BLANK;
            dp_n       <= (w_drive && !w_lz) ? ~DP_MASK[r_dig] : 1'b1;
            frame_done <= w_drive && w_cnt_last && r_dig == 3'd7;
        end
    end

endmodule

// File: tb/tb_io_seg_display.sv
// tb_io_seg_display: scoreboard bench comparing two display configurations to a time-based model
module tb_io_seg_display;

    localparam int SD = 8;
    localparam int GD = 2;
    localparam int FR = 8 * SD;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic [6:0] seg0;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] p0 = '0;
    logic [31:0] p1 = '0;
    logic [31:0] p2 = '0;
    logic [7:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b, fd_a, fd_b;

    int   compared = 0;
    int   mismatched = 0;
    int   t = 0;
    bit   done = 0;
    exp_t q[$];
    logic [31:0] msnap = '0;
    logic [6:0]  hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    io_seg_display #(.SCAN_DIV(SD), .GUARD(GD), .BLANK_LZ(1), .DP_MASK(8'b0101_0000)) dut_a (
        .clock(clk), .reset(reset), .out_port0(p0), .out_port1(p1), .out_port2(p2),
        .an_n(an_a), .seg_n(seg_a), .dp_n(dp_a), .frame_done(fd_a)
    );

    io_seg_display #(.SCAN_DIV(SD), .GUARD(GD), .BLANK_LZ(0), .DP_MASK(8'b0101_0000)) dut_b (
        .clock(clk), .reset(reset), .out_port0(p0), .out_port1(p1), .out_port2(p2),
        .an_n(an_b), .seg_n(seg_b), .dp_n(dp_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] digit_val(input logic [31:0] s, input int d);
        logic [3:0] v;
        case (d)
            7: v = s[31:28];
            6: v = s[27:24];
            5: v = s[23:20];
            4: v = s[19:16];
            default: v = s[d*4 +: 4];
        endcase
        return v;
    endfunction

    function automatic bit leading_zero(input logic [15:0] v, input int d);
        if (d < 1 || d > 3) return 0;
        for (int k = d; k <= 3; k++) if (v[k*4 +: 4] != 4'h0) return 0;
        return 1;
    endfunction

    // reference: the displayed value at time t follows from slot = t/SD and position = t%SD
    always @(posedge clk) begin
        exp_t e;
        int pos, dg;
        bit lit, lz;
        if (reset) begin
            e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fd: 1'b0, seg0: 7'h7F};
            t = 0;
        end else begin
            pos = t % SD;
            dg  = (t / SD) % 8;
            if (t % FR == 0) msnap = {p0[7:0], p1[7:0], p2[15:0]};
            lit = pos >= GD;
            lz  = leading_zero(msnap[15:0], dg);
            e.an   = lit ? ~(8'h01 << dg) : 8'hFF;
            e.seg  = (lit && !lz) ? hex_tbl[digit_val(msnap, dg)] : 7'h7F;
            e.seg0 = lit ? hex_tbl[digit_val(msnap, dg)] : 7'h7F;
            e.dp   = (lit && !lz) ? !(dg == 4 || dg == 6) : 1'b1;
            e.fd   = (t % FR) == FR - 1;
            t++;
        end
        q.push_back(e);
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            if (mismatched <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // monitor: outputs are valid every cycle, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (!done && q.size() > 0) begin
            e = q.pop_front();
            check("an_n", an_a, e.an);
            check("seg_n", seg_a, e.seg);
            check("dp_n", dp_a, e.dp);
            check("frame_done", fd_a, e.fd);
            check("seg_n_nolz", seg_b, e.seg0);
            check("an_n_nolz", an_b, e.an);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int ph);
        int k;
        for (k = 0; k < 4 * FR; k++) begin
            @(negedge clk);
            if (t % FR == ph) break;
        end
        if (k == 4 * FR) begin
            compared++;
            mismatched++;
            $display("FAIL wait_phase: phase %0d not reached, got t=%0d", ph, t);
        end
    endtask

    initial begin
        cycles(3);
        p0 = 32'hDEAD_BEA5;
        p1 = 32'h0000_003C;
        p2 = 32'hFFFF_1234;
        reset = 1'b0;
        cycles(2 * FR);
        wait_phase(26);
        p2 = 32'h0000_FFFF;
        cycles(2 * FR);
        wait_phase(40);
        p2 = 32'h0000_0007;
        cycles(2 * FR);
        wait_phase(10);
        p2 = 32'h0000_0000;
        cycles(2 * FR);
        wait_phase(44);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        p0 = 32'h0000_0081;
        cycles(2 * FR);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                p0 = $urandom;
                p1 = $urandom;
                p2 = $urandom & {16'h0, $urandom_range(0, 1) ? 4'h0 : 4'hF,
                                 $urandom_range(0, 1) ? 4'h0 : 4'hF,
                                 $urandom_range(0, 1) ? 4'h0 : 4'hF, 4'hF};
            end
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            else reset = 1'b0;
        end
        reset = 1'b0;
        p0 = $urandom;
        p1 = $urandom;
        p2 = $urandom & 32'h0000_00FF;
        cycles(3 * FR);
        done = 1;
        if (compared == 0) begin
            mismatched++;
            $display("FAIL monitor: got 0 comparisons expected at least 1");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
